seg14_scan_sched: RTL and testbench

- Refresh scheduler for the 12-digit 14-segment multiplexed display.
- A host loads segment patterns into a shadow message buffer and commits them.
- The block swaps shadow into the active buffer only at frame boundaries, so there is no tearing.
- It time-slices the shared segment bus across the digit selects, inserts an anti-ghosting blank before each digit, and optionally scrolls messages through the display window.

---
 rtl/seg14_scan_sched.sv | 174 +++++++++++++++++
 tb/tb_seg14_scan_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg14_scan_sched.sv
// Refresh scheduler for a multiplexed 14-segment display: double-buffered message,
// per-digit time slicing with a leading blank, and optional scrolling.
module seg14_scan_sched #(
  parameter int NUM_DIGITS    = 12,
  parameter int BUF_DEPTH     = 16,
  parameter int DIGIT_CYCLES  = 4,
  parameter int BLANK_CYCLES  = 1,
  parameter int SCROLL_FRAMES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [3:0]            wr_addr,
  input  logic [13:0]           wr_data,
  input  logic                  commit,
  input  logic [4:0]            commit_len,
  output logic                  commit_done,
  input  logic                  scroll_en,
  output logic                  frame_start,
  output logic [NUM_DIGITS-1:0] sel,
  output logic [13:0]           segm
);

  localparam int SLOT_W = $clog2(DIGIT_CYCLES);
  localparam int DIG_W  = $clog2(NUM_DIGITS);
  localparam int LEN_W  = 5;
  localparam int AW     = 4;
  localparam int SF_W   = $clog2(SCROLL_FRAMES + 1);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGIT_CYCLES - 1);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
  localparam logic [SF_W-1:0]   SF_LAST   = SF_W'(SCROLL_FRAMES - 1);
  localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(BUF_DEPTH);

  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [DIG_W-1:0]     digit_q, digit_d;
  logic [LEN_W-1:0]     offset_q, offset_d;
  logic [LEN_W-1:0]     idx_q, idx_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     active_len_q, active_len_d;
  logic [SF_W-1:0]      sframe_q, sframe_d;
  logic                 pending_q, pending_d;
  logic [13:0]          shadow_q [BUF_DEPTH];
  logic [13:0]          shadow_d [BUF_DEPTH];
  logic [13:0]          active_q [BUF_DEPTH];
  logic [13:0]          active_d [BUF_DEPTH];
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [13:0]          segm_q, segm_d;
  logic                 frame_start_q, frame_start_d;
  logic                 commit_done_q, commit_done_d;

  logic                 slot_end;
  logic                 frame_end;
  logic                 blank;
  logic [LEN_W-1:0]     d_ext;
  logic [13:0]          glyph;

  assign wr_ready    = !pending_q;
  assign commit_done = commit_done_q;
  assign frame_start = frame_start_q;
  assign sel         = sel_q;
  assign segm        = segm_q;

  always_comb begin
    slot_d       = slot_q;
    digit_d      = digit_q;
    offset_d     = offset_q;
    idx_d        = idx_q;
    len_d        = len_q;
    active_len_d = active_len_q;
    sframe_d     = sframe_q;
    pending_d    = pending_q;
    shadow_d     = shadow_q;
    active_d     = active_q;

    slot_end  = (slot_q == SLOT_LAST);
    frame_end = slot_end && (digit_q == DIG_LAST);

    if (wr_valid && !pending_q) begin
      shadow_d[wr_addr] = wr_data;
    end

    if (commit && !pending_q) begin
      pending_d = 1'b1;
      len_d     = (commit_len > LEN_MAX) ? LEN_MAX : commit_len;
    end

    // idx tracks (offset + digit) mod (active_len+1) one step per digit, so no divider is needed
    if (slot_end) begin
      slot_d  = '0;
      digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DIG_W'(1);
      idx_d   = (idx_q == active_len_q) ? '0 : idx_q + LEN_W'(1);
    end else begin
      slot_d = slot_q + SLOT_W'(1);
    end

    if (frame_end) begin
      if (pending_q) begin
        active_d     = shadow_q;
        active_len_d = len_q;
        offset_d     = '0;
        sframe_d     = '0;
        pending_d    = 1'b0;
      end else if (!scroll_en) begin
        offset_d = '0;
        sframe_d = '0;
      end else if (active_len_q != '0) begin
        if (sframe_q == SF_LAST) begin
          sframe_d = '0;
          offset_d = (offset_q == active_len_q) ? '0 : offset_q + LEN_W'(1);
        end else begin
          sframe_d = sframe_q + SF_W'(1);
        end
      end
      idx_d = offset_d;
    end
  end

  always_comb begin
    d_ext = LEN_W'(digit_q);
    glyph = '0;
    if (active_len_q != '0) begin
      if (scroll_en) begin
        if (idx_q < active_len_q) glyph = active_q[idx_q[AW-1:0]];
      end else if (d_ext < active_len_q) begin
        glyph = active_q[d_ext[AW-1:0]];
      end
    end

    blank         = (slot_q < SLOT_W'(BLANK_CYCLES));
    sel_d         = blank ? '0 : (NUM_DIGITS'(1) << digit_q);
    segm_d        = blank ? '0 : glyph;
    frame_start_d = (slot_q == '0) && (digit_q == '0);
    commit_done_d = frame_end && pending_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q        <= '0;
      digit_q       <= '0;
      offset_q      <= '0;
      idx_q         <= '0;
      len_q         <= '0;
      active_len_q  <= '0;
      sframe_q      <= '0;
      pending_q     <= 1'b0;
      sel_q         <= '0;
      segm_q        <= '0;
      frame_start_q <= 1'b0;
      commit_done_q <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      slot_q        <= slot_d;
      digit_q       <= digit_d;
      offset_q      <= offset_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      active_len_q  <= active_len_d;
      sframe_q      <= sframe_d;
      pending_q     <= pending_d;
      sel_q         <= sel_d;
      segm_q        <= segm_d;
      frame_start_q <= frame_start_d;
      commit_done_q <= commit_done_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
    end
  end

endmodule

// File: tb/tb_seg14_scan_sched.sv
// Directed self-checking bench for seg14_scan_sched at default parameters.
module tb_seg14_scan_sched;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_addr;
  logic [13:0] wr_data;
  logic        commit;
  logic [4:0]  commit_len;
  logic        commit_done;
  logic        scroll_en;
  logic        frame_start;
  logic [11:0] sel;
  logic [13:0] segm;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  logic [13:0] sh_m [16];

  seg14_scan_sched dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .commit_len(commit_len), .commit_done(commit_done),
    .scroll_en(scroll_en), .frame_start(frame_start), .sel(sel), .segm(segm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // posedges since reset release; at a negedge the outputs show scan state cyc-1
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cyc=%0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic int dig_of();
    return ((cyc - 1) / 4) % 12;
  endfunction

  function automatic int slot_of();
    return (cyc - 1) % 4;
  endfunction

  task automatic goto_pos(input int d, input int s);
    int k = 0;
    do begin
      step();
      k++;
    end while (!(dig_of() == d && slot_of() == s) && k < 60);
    if (!(dig_of() == d && slot_of() == s)) check_eq("goto_timeout", 32'(k), 32'(0));
  endtask

  function automatic int exp_done_cyc(input int c);
    if (c % 48 == 47) return c + 49;
    return c + (47 - c % 48) + 1;
  endfunction

  task automatic wait_done(input int exp_at);
    int k = 0;
    while (!commit_done && k < 120) begin
      step();
      k++;
    end
    check_eq("commit_done_seen", 32'(commit_done), 32'(1));
    check_eq("commit_done_cycle", 32'(cyc), 32'(exp_at));
  endtask

  function automatic logic [13:0] glyph_m(input int d, input int o, input int len);
    int i = (o + d) % (len + 1);
    return (i < len) ? sh_m[i] : 14'h0;
  endfunction

  task automatic do_commit(input logic [4:0] len, output int c);
    commit     = 1'b1;
    commit_len = len;
    c          = cyc;
    step();
    commit     = 1'b0;
  endtask

  task automatic scroll_check(input int len, input int nfr);
    goto_pos(2, 0);
    scroll_en = 1'b1;
    for (int j = 1; j <= nfr; j++) begin
      int o = (j / 2) % (len + 1);
      goto_pos(0, 1);
      check_eq($sformatf("scroll_d0_f%0d", j), 32'(segm), 32'(glyph_m(0, o, len)));
      goto_pos(11, 1);
      check_eq($sformatf("scroll_d11_f%0d", j), 32'(segm), 32'(glyph_m(11, o, len)));
    end
    scroll_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] pat [16];
    int c, seen, nz;
    pat = '{14'h1BC0, 14'h0879, 14'h2409, 14'h0C70, 14'h0C70, 14'h2409, 14'h003F,
            14'h2401, 14'h003F, 14'h011B, 14'h0001, 14'h0002, 14'h0004, 14'h0008,
            14'h0010, 14'h0020};
    for (int i = 0; i < 16; i++) sh_m[i] = 14'h0;
    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    commit = 1'b0; commit_len = '0; scroll_en = 1'b0;

    // reset values
    repeat (3) step();
    check_eq("rst_sel", 32'(sel), 32'(0));
    check_eq("rst_segm", 32'(segm), 32'(0));
    check_eq("rst_frame_start", 32'(frame_start), 32'(0));
    check_eq("rst_commit_done", 32'(commit_done), 32'(0));
    check_eq("rst_wr_ready", 32'(wr_ready), 32'(1));
    rst_n = 1'b1;

    // idle scan pattern
    for (int k = 0; k < 100; k++) begin
      step();
      check_eq("idle_sel", 32'(sel), (slot_of() == 0) ? 32'(0) : (32'(1) << dig_of()));
      check_eq("idle_segm", 32'(segm), 32'(0));
      check_eq("idle_frame_start", 32'(frame_start), 32'(((cyc - 1) % 48) == 0));
      check_eq("idle_wr_ready", 32'(wr_ready), 32'(1));
    end

    // load message and publish
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1; wr_addr = 4'(i); wr_data = pat[i];
      sh_m[i] = pat[i];
      step();
    end
    wr_valid = 1'b0;
    do_commit(5'd10, c);
    check_eq("pending_wr_ready", 32'(wr_ready), 32'(0));
    wait_done(exp_done_cyc(c));
    check_eq("post_done_wr_ready", 32'(wr_ready), 32'(1));
    goto_pos(0, 1);
    check_eq("msg_sel_d0", 32'(sel), 32'h001);
    check_eq("msg_segm_d0", 32'(segm), 32'h1BC0);
    for (int d = 1; d < 12; d++) begin
      goto_pos(d, 1);
      check_eq($sformatf("msg_sel_d%0d", d), 32'(sel), 32'(1) << d);
      check_eq($sformatf("msg_segm_d%0d", d), 32'(segm), (d < 10) ? 32'(pat[d]) : 32'(0));
    end

    // writes and a second commit are blocked while pending
    goto_pos(5, 0);
    do_commit(5'd10, c);
    wr_valid = 1'b1; wr_addr = 4'd0; wr_data = 14'h3FFF;
    commit = 1'b1; commit_len = 5'd3;
    #1;
    check_eq("blocked_wr_ready", 32'(wr_ready), 32'(0));
    step();
    wr_valid = 1'b0; commit = 1'b0;
    wait_done(exp_done_cyc(c));
    goto_pos(0, 1);
    check_eq("blocked_segm_d0", 32'(segm), 32'h1BC0);
    goto_pos(9, 1);
    check_eq("len_kept_d9", 32'(segm), 32'(pat[9]));
    goto_pos(10, 1);
    check_eq("len_kept_d10", 32'(segm), 32'(0));

    // scrolling, full wrap of an 11-position cycle
    scroll_check(10, 23);

    // commit exactly in the boundary cycle, length saturated
    for (int i = 10; i < 16; i++) begin
      wr_valid = 1'b1; wr_addr = 4'(i); wr_data = pat[i];
      sh_m[i] = pat[i];
      step();
    end
    wr_valid = 1'b0;
    begin
      int k = 0;
      while (cyc % 48 != 47 && k < 60) begin step(); k++; end
    end
    do_commit(5'd20, c);
    check_eq("bnd_commit_c", 32'(c % 48), 32'(47));
    check_eq("bnd_no_early_done", 32'(commit_done), 32'(0));
    wait_done(c + 49);
    goto_pos(10, 1);
    check_eq("sat_segm_d10", 32'(segm), 32'(pat[10]));
    scroll_check(16, 12);

    // async reset with a commit pending
    goto_pos(3, 1);
    do_commit(5'd4, c);
    #2;
    check_eq("pre_rst_sel_nonzero", 32'(sel != 0), 32'(1));
    rst_n = 1'b0;
    #1;
    check_eq("arst_sel", 32'(sel), 32'(0));
    check_eq("arst_segm", 32'(segm), 32'(0));
    check_eq("arst_wr_ready", 32'(wr_ready), 32'(1));
    check_eq("arst_commit_done", 32'(commit_done), 32'(0));
    step();
    rst_n = 1'b1;
    seen = 0; nz = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (commit_done) seen++;
      if (segm != 0) nz++;
    end
    check_eq("arst_no_commit_done", 32'(seen), 32'(0));
    check_eq("arst_active_cleared", 32'(nz), 32'(0));
    for (int i = 0; i < 16; i++) sh_m[i] = 14'h0;
    do_commit(5'd4, c);
    wait_done(exp_done_cyc(c));
    goto_pos(0, 1);
    check_eq("arst_shadow_sel", 32'(sel), 32'h001);
    check_eq("arst_shadow_cleared", 32'(segm), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
